// File: rtl/cache_ctrl_proc.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl_proc
// Purpose  : Direct-mapped, write-through, no-write-allocate data cache
//            between the MEM stage and the SRAM controller.
// Revision : 1.0
// ============================================================================
module cache_ctrl_proc #(
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrEnIn,
  input  logic        rdEnIn,
  input  logic [31:0] addressIn,
  input  logic [31:0] writeDataIn,
  output logic [31:0] readDataOut,
  output logic        readyOut,
  output logic        sramWrEnOut,
  output logic        sramRdEnOut,
  output logic [31:0] sramAddressOut,
  output logic [31:0] sramWriteDataOut,
  input  logic [31:0] sramReadDataIn,
  input  logic        sramReadyIn
);

  localparam int          c_TAG_W = 17 - INDEX_W;
  localparam int          c_LINES = 1 << INDEX_W;
  localparam logic [31:0] c_BASE  = 32'd1024;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t             r_state;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_read_data;
  logic [c_LINES-1:0] r_valid;
  logic [c_TAG_W-1:0] r_tag  [c_LINES];
  logic [31:0]        r_data [c_LINES];

  logic [31:0]        w_req_mem;
  logic [31:0]        w_lat_mem;
  logic [INDEX_W-1:0] w_req_idx;
  logic [INDEX_W-1:0] w_lat_idx;
  logic [c_TAG_W-1:0] w_req_tag;
  logic [c_TAG_W-1:0] w_lat_tag;
  logic               w_hit;
  logic               w_idle_hit;
  logic               w_lat_resident;
  logic               w_fill_done;
  logic               w_write_done;
  logic               w_unused_addr_bits;

  // Request address is decoded live; the latched copy drives FILL/WRITE.
  assign w_req_mem = addressIn - c_BASE;
  assign w_lat_mem = r_addr - c_BASE;
  assign w_req_idx = w_req_mem[2 +: INDEX_W];
  assign w_lat_idx = w_lat_mem[2 +: INDEX_W];
  assign w_req_tag = w_req_mem[18:2+INDEX_W];
  assign w_lat_tag = w_lat_mem[18:2+INDEX_W];
  assign w_unused_addr_bits = ^{w_req_mem[31:19], w_req_mem[1:0],
                                w_lat_mem[31:19], w_lat_mem[1:0]};

  assign w_hit          = rdEnIn & r_valid[w_req_idx] & (r_tag[w_req_idx] == w_req_tag);
  assign w_idle_hit     = (r_state == S_IDLE) & ~wrEnIn & w_hit;
  assign w_lat_resident = r_valid[w_lat_idx] & (r_tag[w_lat_idx] == w_lat_tag);
  assign w_fill_done    = (r_state == S_FILL) & sramReadyIn;
  assign w_write_done   = (r_state == S_WRITE) & sramReadyIn;

  assign sramAddressOut   = r_addr;
  assign sramWriteDataOut = r_wdata;
  assign readDataOut      = w_fill_done ? sramReadDataIn :
                            w_idle_hit  ? r_data[w_req_idx] : r_read_data;

  always_comb begin
    readyOut = 1'b0;
    case (r_state)
      S_IDLE:          readyOut = ~wrEnIn & ~(rdEnIn & ~w_hit);
      S_FILL, S_WRITE: readyOut = sramReadyIn;
      default:         readyOut = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_read_data <= '0;
      sramRdEnOut <= 1'b0;
      sramWrEnOut <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (wrEnIn) begin
            r_addr      <= addressIn;
            r_wdata     <= writeDataIn;
            r_state     <= S_WRITE;
            sramWrEnOut <= 1'b1;
          end else if (rdEnIn && !w_hit) begin
            r_addr      <= addressIn;
            r_state     <= S_FILL;
            sramRdEnOut <= 1'b1;
          end else if (w_hit) begin
            r_read_data <= r_data[w_req_idx];
          end
        end
        S_FILL: begin
          if (sramReadyIn) begin
            r_valid[w_lat_idx] <= 1'b1;
            r_read_data        <= sramReadDataIn;
            r_state            <= S_IDLE;
            sramRdEnOut        <= 1'b0;
          end
        end
        S_WRITE: begin
          if (sramReadyIn) begin
            r_state     <= S_IDLE;
            sramWrEnOut <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          sramRdEnOut <= 1'b0;
          sramWrEnOut <= 1'b0;
        end
      endcase
    end
  end

  // Tag/data storage carries no reset; a reset cycle must not commit a line.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (w_fill_done) begin
        r_tag[w_lat_idx]  <= w_lat_tag;
        r_data[w_lat_idx] <= sramReadDataIn;
      end else if (w_write_done && w_lat_resident) begin
        r_data[w_lat_idx] <= r_wdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/cache_ctrl_proc.md
Name: cache_ctrl_proc

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and the SRAM controller.
- Pipeline side: same request interface the MEM stage drives today (wrEnIn/rdEnIn/addressIn/writeDataIn, readDataOut/readyOut freeze).
- Memory side: drives the SRAM controller's wrEnIn/rdEnIn/addressIn/writeDataIn and consumes its readDataOut/readyOut.
- Read hits finish with zero wait states; misses and all writes go through the SRAM controller.

Parameters:
INDEX_W, 6, line-index width; 2**INDEX_W lines of one 32-bit word each; tag width = 17 - INDEX_W.

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  synchronous, active-low reset
wrEnIn  input  1  pipeline write request
rdEnIn  input  1  pipeline read request
addressIn  input  32  byte address, data region based at 1024, word aligned
writeDataIn  input  32  store data
readDataOut  output  32  load data, valid when readyOut=1 with rdEnIn
readyOut  output  1  0 = freeze pipeline
sramWrEnOut  output  1  to SRAM controller wrEnIn
sramRdEnOut  output  1  to SRAM controller rdEnIn
sramAddressOut  output  32  to SRAM controller addressIn; raw pipeline address, unmodified
sramWriteDataOut  output  32  to SRAM controller writeDataIn
sramReadDataIn  input  32  from SRAM controller readDataOut
sramReadyIn  input  1  from SRAM controller readyOut

Behaviour:
- Address split:
  - memAddr = addressIn - 1024.
  - index = memAddr[2+INDEX_W-1:2].
  - tag = memAddr[18:2+INDEX_W].
  - memAddr[1:0] ignored.
- Storage: per line, valid bit, tag and 32-bit data.
- hit = rdEnIn & valid[index] & (tag match).
- Request priority: if wrEnIn and rdEnIn are both 1, the request is treated as a write.
- States: IDLE, FILL, WRITE.
- Reset (rst=0 at posedge):
  - state -> IDLE.
  - All valid bits -> 0.
  - Latched address/data -> 0; readDataOut -> 0.
  - sramWrEnOut = sramRdEnOut = 0 from the next cycle.
- IDLE:
  - No request: readyOut=1.
  - Read hit: readyOut=1 and readDataOut=line data in the same cycle; state stays IDLE; no SRAM activity.
  - Read miss: readyOut=0; latch addressIn; -> FILL.
  - Write (hit or miss): readyOut=0; latch addressIn and writeDataIn; -> WRITE.
- FILL:
  - sramRdEnOut=1; sramAddressOut = latched address; readyOut=0 until completion.
  - Completion cycle (sramReadyIn=1):
    - Line at index gets valid=1, tag, data=sramReadDataIn.
    - readDataOut=sramReadDataIn and readyOut=1 in that cycle.
    - -> IDLE.
- WRITE:
  - sramWrEnOut=1; sramAddressOut, sramWriteDataOut = latched values.
  - Completion cycle (sramReadyIn=1): readyOut=1.
    - Line valid with matching tag: line data updated to the latched data.
    - Otherwise: cache array untouched (no allocate).
    - -> IDLE.
- sramRdEnOut and sramWrEnOut depend only on state (Moore).
  - Both are 0 in IDLE, so the SRAM controller sees at least one deasserted cycle between transactions.
  - sramReadyIn is sampled only in FILL/WRITE; its value in IDLE is ignored.
- While readyOut=0 the pipeline holds its inputs stable. The cache uses only latched values in FILL/WRITE, so input changes there have no effect.
- Reset mid-FILL/WRITE: transaction abandoned; no line is written; IDLE next cycle.
- Miss latency = 1 (IDLE detect) + SRAM controller latency; the current controller takes 6 cycles after enable.
- Array may be registers; no reset on data/tag storage, only on valid bits.

Test Plan:
- Reset, then idle with no request -> readyOut=1, sramRdEnOut=sramWrEnOut=0, readDataOut=0.
- Read 1024 after reset (SRAM model returns 0xDEADBEEF after 6 cycles) -> readyOut=0 for 7 cycles, sramRdEnOut=1 with sramAddressOut=1024; readyOut=1 and readDataOut=0xDEADBEEF on the sramReadyIn cycle.
- Read 1024 again -> readyOut=1 and 0xDEADBEEF in the same cycle, sramRdEnOut stays 0.
- Conflict: read 1280 (index 0, new tag, SRAM 0x0000CAFE) -> miss; then read 1024 -> miss again, SRAM read re-issued.
- Write 0x12345678 to 1280 while it is resident -> sramWrEnOut=1, sramWriteDataOut=0x12345678, readyOut on sramReadyIn; then read 1280 -> hit 0x12345678, no SRAM read.
- Write 0xAAAA5555 to 1028 (not resident) -> SRAM write only; following read 1028 -> miss and fill.
- rst=0 during FILL of 1032 -> IDLE next cycle, enables 0; read 1024 afterwards -> miss (valid cleared).
